// File: rtl/sw_debounce_enc.sv
// ---------------------------------------------------------------------------
// sw_debounce_enc: two-flop sync + vector debounce of 16 slide switches, LSB-priority index encode. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sw_debounce_enc #(
  parameter int DEBOUNCE = 20
) (
  input  logic        clk_1k,
  input  logic        reset,
  input  logic [15:0] sw,
  output logic [15:0] stable_sw,
  output logic [3:0]  idx,
  output logic        valid,
  output logic        multi,
  output logic        change
);

  localparam logic [9:0] CNT_LAST = 10'(DEBOUNCE - 1);

  typedef enum logic [0:0] {
    STABLE = 1'b0,
    SETTLE = 1'b1
  } state_t;

  logic [15:0] s1, s2;
  logic [15:0] cand, cand_nxt;
  logic [9:0]  cnt, cnt_nxt;
  state_t      state, state_nxt;
  logic        commit;

  logic [3:0]  enc_idx;
  logic        enc_valid;
  logic        enc_multi;

  always_ff @(posedge clk_1k or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk_1k or negedge reset) begin
    if (!reset) begin
      state <= STABLE;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cand  <= cand_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Bounce-back to the committed value wins over a restart, which wins over commit.
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      STABLE: begin
        if (s2 != stable_sw) begin
          cand_nxt  = s2;
          cnt_nxt   = '0;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (s2 == stable_sw) begin
          state_nxt = STABLE;
        end else if (s2 != cand) begin
          cand_nxt = s2;
          cnt_nxt  = '0;
        end else if (cnt == CNT_LAST) begin
          commit    = 1'b1;
          state_nxt = STABLE;
        end else begin
          cnt_nxt = cnt + 10'd1;
        end
      end
    endcase
  end

  // Scan downward so the lowest set bit is the last to write the index.
  always_comb begin
    enc_idx = '0;
    for (int n = 15; n >= 0; n--) begin
      if (cand[n]) enc_idx = 4'(n);
    end
  end

  assign enc_valid = |cand;
  assign enc_multi = |(cand & (cand - 16'd1));

  always_ff @(posedge clk_1k or negedge reset) begin
    if (!reset) begin
      stable_sw <= '0;
      idx       <= '0;
      valid     <= 1'b0;
      multi     <= 1'b0;
      change    <= 1'b0;
    end else begin
      change <= commit;
      if (commit) begin
        stable_sw <= cand;
        idx       <= enc_idx;
        valid     <= enc_valid;
        multi     <= enc_multi;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sw_debounce_enc.sv
// ---------------------------------------------------------------------------
// tb_sw_debounce_enc: randomized + directed bench for sw_debounce_enc at DEBOUNCE 20 and 2. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sw_debounce_enc;

  localparam int DEB_A = 20;
  localparam int DEB_B = 2;

  logic        clk_1k = 1'b0;
  logic        reset  = 1'b0;
  logic [15:0] sw     = '0;

  logic [15:0] stable_sw_a, stable_sw_b;
  logic [3:0]  idx_a, idx_b;
  logic        valid_a, valid_b, multi_a, multi_b, change_a, change_b;

  int tests = 0;
  int fails = 0;
  int pulses_a = 0;
  int pulses_b = 0;

  always #5 clk_1k = ~clk_1k;

  sw_debounce_enc #(.DEBOUNCE(DEB_A)) dut_a (
    .clk_1k(clk_1k), .reset(reset), .sw(sw),
    .stable_sw(stable_sw_a), .idx(idx_a), .valid(valid_a),
    .multi(multi_a), .change(change_a)
  );

  sw_debounce_enc #(.DEBOUNCE(DEB_B)) dut_b (
    .clk_1k(clk_1k), .reset(reset), .sw(sw),
    .stable_sw(stable_sw_b), .idx(idx_b), .valid(valid_b),
    .multi(multi_b), .change(change_b)
  );

  // Reference: a value commits once the synchronized input has shown it,
  // differing from the committed value, on DEBOUNCE+1 consecutive edges.
  logic [15:0] m_s1, m_s2, run_val;
  int          run_len;
  logic [15:0] m_stable [2];
  logic [3:0]  m_idx    [2];
  logic        m_valid  [2];
  logic        m_multi  [2];
  logic        m_change [2];

  function automatic logic [3:0] low_idx(input logic [15:0] v);
    for (int n = 0; n < 16; n++) if (v[n]) return 4'(n);
    return 4'd0;
  endfunction

  always @(posedge clk_1k or negedge reset) begin
    if (!reset) begin
      m_s1 = '0; m_s2 = '0; run_val = '0; run_len = 0;
      for (int i = 0; i < 2; i++) begin
        m_stable[i] = '0; m_idx[i] = '0; m_valid[i] = 1'b0;
        m_multi[i] = 1'b0; m_change[i] = 1'b0;
      end
    end else begin
      if (m_s2 == run_val) begin
        if (run_len < 1000000) run_len++;
      end else begin
        run_val = m_s2;
        run_len = 1;
      end
      for (int i = 0; i < 2; i++) begin
        m_change[i] = 1'b0;
        if (run_val != m_stable[i] && run_len == ((i == 0) ? DEB_A : DEB_B) + 1) begin
          m_stable[i] = run_val;
          m_idx[i]    = low_idx(run_val);
          m_valid[i]  = (run_val != 16'd0);
          m_multi[i]  = ($countones(run_val) >= 2);
          m_change[i] = 1'b1;
        end
      end
      m_s2 = m_s1;
      m_s1 = sw;
    end
  end

  task automatic cmp_inst(input int i, input logic [15:0] s, input logic [3:0] x,
                          input logic v, input logic m, input logic c);
    tests++;
    if (s !== m_stable[i] || x !== m_idx[i] || v !== m_valid[i] ||
        m !== m_multi[i] || c !== m_change[i]) begin
      fails++;
      $display("FAIL model_cmp inst%0d t=%0t: dut sw=%h idx=%0d v=%b m=%b c=%b, model sw=%h idx=%0d v=%b m=%b c=%b",
               i, $time, s, x, v, m, c, m_stable[i], m_idx[i], m_valid[i], m_multi[i], m_change[i]);
    end
  endtask

  always @(negedge clk_1k) begin
    cmp_inst(0, stable_sw_a, idx_a, valid_a, multi_a, change_a);
    cmp_inst(1, stable_sw_b, idx_b, valid_b, multi_b, change_b);
    if (change_a === 1'b1) pulses_a++;
    if (change_b === 1'b1) pulses_b++;
  end

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Move just past the falling edge so literal checks never race the compare process.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk_1k);
      #1;
    end
  endtask

  int          p;
  logic [15:0] prev;
  int          cyc;
  int          hold;
  logic [15:0] val;

  initial begin
    step(3);
    expect_eq("reset_stable", {16'd0, stable_sw_a}, 32'd0);
    expect_eq("reset_flags", {idx_a, valid_a, multi_a, change_a}, 32'd0);
    reset = 1'b1;
    step(100);
    expect_eq("idle_no_pulse_a", pulses_a, 0);
    expect_eq("idle_no_pulse_b", pulses_b, 0);
    expect_eq("idle_stable", {16'd0, stable_sw_a}, 32'd0);

    // Single-bit step: E21 unchanged, E22 committed.
    sw = 16'h0008;
    step(22);
    expect_eq("step_e21_stable", {16'd0, stable_sw_a}, 32'd0);
    expect_eq("step_e21_change", {31'd0, change_a}, 32'd0);
    step();
    expect_eq("step_e22_stable", {16'd0, stable_sw_a}, 32'h0008);
    expect_eq("step_e22_flags", {idx_a, valid_a, multi_a, change_a}, {25'd0, 4'd3, 3'b101});
    step();
    expect_eq("step_change_drop", {31'd0, change_a}, 32'd0);
    expect_eq("step_pulse_count", pulses_a, 1);

    // Short glitch then a toggling burst.
    sw = 16'h0000;
    step(30);
    p = pulses_a;
    sw = 16'h0010;
    step(5);
    sw = 16'h0000;
    step(30);
    expect_eq("glitch_no_commit", pulses_a, p);
    expect_eq("glitch_stable", {16'd0, stable_sw_a}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      sw = (k % 2 == 0) ? 16'h0010 : 16'h0000;
      step(7);
    end
    sw = 16'h0010;
    step(22);
    expect_eq("toggle_pre_commit", {16'd0, stable_sw_a}, 32'd0);
    step();
    expect_eq("toggle_commit", {15'd0, stable_sw_a, change_a}, {15'd0, 16'h0010, 1'b1});

    // Multi-select and LSB priority.
    sw = 16'h8001;
    step(30);
    expect_eq("multi_flags", {idx_a, valid_a, multi_a}, {25'd0, 4'd0, 2'b11});
    p = pulses_a;
    sw = 16'h8000;
    step(30);
    expect_eq("single15_flags", {idx_a, valid_a, multi_a}, {25'd0, 4'd15, 2'b10});
    expect_eq("single15_pulse", pulses_a, p + 1);

    // Reset ten cycles into SETTLE.
    sw = 16'h0000;
    step(30);
    sw = 16'h0040;
    step(13);
    expect_eq("settle_no_commit", {16'd0, stable_sw_a}, 32'd0);
    reset = 1'b0;
    step();
    expect_eq("rst_outputs_a", {stable_sw_a, idx_a, valid_a, multi_a, change_a}, 32'd0);
    expect_eq("rst_outputs_b", {16'd0, stable_sw_b}, 32'd0);
    step(2);
    reset = 1'b1;
    step(22);
    expect_eq("post_rst_pre", {16'd0, stable_sw_a}, 32'd0);
    step();
    expect_eq("post_rst_commit", {15'd0, stable_sw_a, change_a}, {15'd0, 16'h0040, 1'b1});

    // DEBOUNCE=2 walking bit: commit 4 edges after each step.
    prev = stable_sw_b;
    expect_eq("walk_start", {16'd0, prev}, 32'h0040);
    for (int n = 0; n < 16; n++) begin
      sw = 16'd1 << n;
      step(4);
      expect_eq($sformatf("walk%0d_pre", n), {16'd0, stable_sw_b}, {16'd0, prev});
      step();
      expect_eq($sformatf("walk%0d_commit", n), {11'd0, stable_sw_b, idx_b, change_b},
                {11'd0, 16'd1 << n, 4'(n), 1'b1});
      prev = 16'd1 << n;
      step(2);
    end

    // Randomized bursts, long holds and occasional resets.
    cyc = 0;
    while (cyc < 4000) begin
      hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(20, 40)) : int'($urandom_range(1, 8));
      case ($urandom_range(0, 3))
        0: val = 16'd1 << $urandom_range(0, 15);
        1: val = 16'($urandom) & 16'h0f0f;
        2: val = m_stable[0];
        default: val = 16'($urandom);
      endcase
      sw = val;
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b0;
        step($urandom_range(1, 3));
        reset = 1'b1;
      end
      step(hold);
      cyc += hold;
    end

    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sw_debounce_enc.md
# sw_debounce_enc

Input-side companion to the LED one-hot display path: samples the 16 board slide switches on the 1 kHz clock, synchronizes and debounces them as a vector, and encodes the settled pattern into a 4-bit index. The index matches the LED chaser's count encoding, so switch position N corresponds to LED N. It sits between the raw switch pins and any logic that consumes a switch-selected position; it also flags invalid multi-switch selections.

## Interface
- DEBOUNCE, 20, settle time in clk_1k cycles (ms); legal range 2..1023
- clk_1k  input  1  1 kHz system tick clock, all state on rising edge
- reset  input  1  asynchronous, active-low
- sw  input  16  raw asynchronous switch levels, bit N = switch N
- stable_sw  output  16  debounced switch vector
- idx  output  4  index of lowest set bit of stable_sw; 0 when none set
- valid  output  1  at least one bit of stable_sw set
- multi  output  1  two or more bits of stable_sw set
- change  output  1  one-cycle pulse when stable_sw takes a new value

## Operation
- Synchronizer: two flops, sw -> s1 -> s2. Only s2 is used downstream.
- Registers: cand[15:0], cnt[9:0], state in {STABLE, SETTLE}.
- STABLE:
  - s2 == stable_sw: hold.
  - Otherwise: cand <= s2, cnt <= 0, go to SETTLE.
- SETTLE, in priority order:
  - s2 == stable_sw: bounce back to the committed value. Go to STABLE; no commit, no change pulse.
  - s2 != cand: cand <= s2, cnt <= 0, stay in SETTLE (restart).
  - cnt == DEBOUNCE-1: commit (stable_sw <= cand, outputs update, change <= 1), go to STABLE.
  - Otherwise: cnt <= cnt + 1.
- Encode on commit, registered in the same edge as stable_sw:
  - idx = lowest N with cand[N] = 1; LSB priority; 0 when cand == 0.
  - valid = |cand.
  - multi = popcount(cand) >= 2.
- change is high exactly one cycle after each commit and low in all other cycles.
- cnt never wraps: it is bounded by DEBOUNCE-1 ≤ 1022.

## Timing
- Reset (asynchronous assert, low): s1, s2, cand, cnt, stable_sw, idx, valid, multi and change all 0; state = STABLE.
- Reset asserted mid-SETTLE discards the candidate. After release the block treats 0 as the stable value.
- Latency: sw changes and is held; its first sampling edge is E0.
  - s2 updates at E1.
  - SETTLE is entered at E2.
  - Commit is at edge E(2+DEBOUNCE); outputs are valid after that edge.
  - For DEBOUNCE = 20: 22 edges, about 22 ms.
- Any s2 change during SETTLE to a third value restarts the full DEBOUNCE window from that edge.
- Simultaneous multi-bit changes within one sample are treated as a single vector change, with a single window.
- Consecutive commits are separated by at least DEBOUNCE+1 cycles.

## Test plan
- Reset, then hold sw = 0 for 100 cycles -> all outputs 0; change never pulses.
- With DEBOUNCE = 20: step sw from 0x0000 to 0x0008 at E0 -> at E22, stable_sw = 0x0008, idx = 3, valid = 1, multi = 0, change = 1 for exactly one cycle; outputs unchanged at E21.
- Bounce: sw = 0x0010 for 5 cycles, then back to 0x0000 -> no commit, change stays 0. Then 0x0010 toggled every 7 cycles for 40 cycles, then held -> commit occurs 22 cycles after the final edge.
- Multi-select: sw = 0x8001 held -> idx = 0, valid = 1, multi = 1. Then sw = 0x8000 -> idx = 15, multi = 0, change pulses again.
- Reset mid-operation: assert reset 10 cycles into SETTLE toward 0x0040, then release with sw still 0x0040 -> outputs 0 during reset; commit 22 cycles after the first post-release edge.
- Boundary DEBOUNCE = 2: single-bit steps across all 16 positions -> idx = 0..15 in order, each commit 4 edges after its step.
